// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus bundle: imem req/ready fetch port, IR load port, decode/execute control.
// master = fetch unit side, slave = memory/pipeline side.
interface instruction_fetch_unit_if;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        ir_load;
   logic [31:0] ir_instruction;
   logic [31:0] ir_pc;

   modport master (
      input  stall, redirect, redirect_pc,
      input  imem_ready, imem_rdata,
      output imem_req, imem_addr,
      output ir_load, ir_instruction, ir_pc
   );

   modport slave (
      output stall, redirect, redirect_pc,
      output imem_ready, imem_rdata,
      input  imem_req, imem_addr,
      input  ir_load, ir_instruction, ir_pc
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC, imem req/ready fetch, prefetch FIFO feeding the IR.
// FETCH_ALIGN_CHECK_EN adds a sticky misaligned-redirect output flag.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned PC_STEP    = 4,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic clk,
   input  logic reset,
`ifdef FETCH_ALIGN_CHECK_EN
   output logic misaligned,
`endif
   instruction_fetch_unit_if.master bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [0:0]  S_FETCH = 1'b0;
   localparam logic [0:0]  S_DROP  = 1'b1;
   localparam logic [AW:0] DEPTH   = FIFO_DEPTH[AW:0];
   localparam logic [31:0] STEP    = PC_STEP[31:0];

   logic [0:0]    r_state;
   logic [31:0]   r_pc;
   logic [31:0]   r_target;
   logic          r_req;
   logic [AW:0]   r_count;
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [31:0]   r_fifo_pc  [FIFO_DEPTH];
   logic [31:0]   r_fifo_ins [FIFO_DEPTH];
   logic          r_ir_load;
   logic [31:0]   r_ir_instr;
   logic [31:0]   r_ir_pc;

   logic          w_xfer;
   logic          w_push;
   logic          w_pop;
   logic [AW:0]   w_count_nxt;
   logic [31:0]   w_target;

   assign w_xfer   = r_req & bus.imem_ready;
   assign w_push   = w_xfer & (r_state == S_FETCH) & ~bus.redirect;
   assign w_pop    = (r_count != '0) & ~bus.stall & ~bus.redirect;
   assign w_target = bus.redirect_pc & 32'hFFFF_FFFC;

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop)
         w_count_nxt = r_count + 1'b1;
      else if (!w_push && w_pop)
         w_count_nxt = r_count - 1'b1;
   end

   // Request is only raised when the FIFO will still have room at the next edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_FETCH;
         r_pc     <= RESET_PC;
         r_target <= RESET_PC;
         r_req    <= 1'b0;
      end else if (bus.redirect) begin
         r_target <= w_target;
         if (r_req && !bus.imem_ready) begin
            r_state <= S_DROP;
         end else begin
            r_state <= S_FETCH;
            r_pc    <= w_target;
            r_req   <= 1'b1;
         end
      end else if (r_state == S_DROP) begin
         if (w_xfer) begin
            r_state <= S_FETCH;
            r_pc    <= r_target;
            r_req   <= 1'b1;
         end
      end else begin
         if (w_xfer)
            r_pc <= r_pc + STEP;
         r_req <= (w_count_nxt < DEPTH);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_pc[r_wr_ptr]  <= r_pc;
         r_fifo_ins[r_wr_ptr] <= bus.imem_rdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count    <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_ir_load  <= 1'b0;
         r_ir_instr <= 32'h0;
         r_ir_pc    <= 32'h0;
      end else if (bus.redirect) begin
         r_count   <= '0;
         r_rd_ptr  <= '0;
         r_wr_ptr  <= '0;
         r_ir_load <= 1'b0;
      end else begin
         r_count   <= w_count_nxt;
         r_ir_load <= w_pop;
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) begin
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_ir_instr <= r_fifo_ins[r_rd_ptr];
            r_ir_pc    <= r_fifo_pc[r_rd_ptr];
         end
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         misaligned <= 1'b0;
      else if (bus.redirect && (bus.redirect_pc[1:0] != 2'b00))
         misaligned <= 1'b1;
   end
`endif

   assign bus.imem_req       = r_req;
   assign bus.imem_addr      = r_pc;
   assign bus.ir_load        = r_ir_load;
   assign bus.ir_instruction = r_ir_instr;
   assign bus.ir_pc          = r_ir_pc;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: streaming, throttled imem,
// stall back-pressure, redirects (pending, overwrite, wrap, misaligned), async reset.
module tb_instruction_fetch_unit;
   logic clk;
   logic reset;
   int   n_assert;
   int   n_fail;
`ifdef FETCH_ALIGN_CHECK_EN
   logic misaligned;
`endif

   instruction_fetch_unit_if bus ();

   instruction_fetch_unit dut (
      .clk        (clk),
      .reset      (reset),
`ifdef FETCH_ALIGN_CHECK_EN
      .misaligned (misaligned),
`endif
      .bus        (bus.master)
   );

   // Memory model: word at an address is the address XOR a fixed tag.
   assign bus.imem_rdata = bus.imem_addr ^ 32'hDEAD_0000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_ir(input string tag, input logic ld,
                         input logic [31:0] pc);
      chk1({tag, "_ld"}, bus.ir_load, ld);
      if (ld) begin
         chk32({tag, "_pc"}, bus.ir_pc, pc);
         chk32({tag, "_ins"}, bus.ir_instruction, pc ^ 32'hDEAD_0000);
      end
   endtask

   task automatic do_reset();
      reset           = 1'b0;
      bus.stall       = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.imem_ready  = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   initial begin
      logic ld;
      n_assert = 0;
      n_fail   = 0;

      // Reset state
      do_reset();
      chk1("rst_req", bus.imem_req, 1'b0);
      chk32("rst_addr", bus.imem_addr, 32'h0);
      chk1("rst_ld", bus.ir_load, 1'b0);
      chk32("rst_ins", bus.ir_instruction, 32'h0);
      chk32("rst_pc", bus.ir_pc, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
      chk1("rst_mis", misaligned, 1'b0);
`endif

      // T1: ready always, no stall
      bus.imem_ready = 1'b1;
      step();
      chk1("t1_req", bus.imem_req, 1'b1);
      chk32("t1_addr0", bus.imem_addr, 32'h0);
      chk_ir("t1_e1", 1'b0, 32'h0);
      step();
      chk32("t1_addr4", bus.imem_addr, 32'h4);
      chk_ir("t1_e2", 1'b0, 32'h0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk_ir("t1_seq", 1'b1, 32'(k * 4));
      end

      // T2: ready on every third cycle
      do_reset();
      for (int k = 1; k <= 12; k++) begin
         step();
         ld = (k % 3 == 2) && (k >= 5);
         chk_ir("t2", ld, 32'(((k - 5) / 3) * 4));
         bus.imem_ready = (k % 3 == 0);
      end

      // T3: stall fills FIFO, request drops, release resumes in order
      do_reset();
      bus.imem_ready = 1'b1;
      bus.stall      = 1'b1;
      step();
      step();
      chk1("t3_req_e2", bus.imem_req, 1'b1);
      step();
      chk1("t3_req_e3", bus.imem_req, 1'b0);
      chk32("t3_addr_e3", bus.imem_addr, 32'h8);
      for (int k = 4; k <= 6; k++) begin
         step();
         chk1("t3_req_hold", bus.imem_req, 1'b0);
         chk32("t3_addr_hold", bus.imem_addr, 32'h8);
         chk_ir("t3_stall", 1'b0, 32'h0);
      end
      bus.stall = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk_ir("t3_rel", 1'b1, 32'(k * 4));
      end

      // T4: redirect with request pending
      do_reset();
      step();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h0000_0100;
      step();
      chk1("t4_req_hold", bus.imem_req, 1'b1);
      chk32("t4_addr_hold", bus.imem_addr, 32'h0);
      chk_ir("t4_flush", 1'b0, 32'h0);
      bus.redirect   = 1'b0;
      bus.imem_ready = 1'b1;
      step();
      chk32("t4_addr_tgt", bus.imem_addr, 32'h100);
      chk_ir("t4_drop", 1'b0, 32'h0);
      step();
      chk32("t4_addr_nxt", bus.imem_addr, 32'h104);
      chk_ir("t4_nostale", 1'b0, 32'h0);
      step();
      chk_ir("t4_first", 1'b1, 32'h100);
      step();
      chk_ir("t4_second", 1'b1, 32'h104);

      // T4b: second redirect while dropping overwrites the target
      do_reset();
      step();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h0000_0100;
      step();
      bus.redirect_pc = 32'h0000_0200;
      step();
      chk1("t4b_req", bus.imem_req, 1'b1);
      chk32("t4b_addr", bus.imem_addr, 32'h0);
      bus.redirect   = 1'b0;
      bus.imem_ready = 1'b1;
      step();
      chk32("t4b_tgt", bus.imem_addr, 32'h200);
      step();
      chk_ir("t4b_e5", 1'b0, 32'h0);
      step();
      chk_ir("t4b_first", 1'b1, 32'h200);

      // T5: redirect coinciding with a transfer and a pop, then PC wrap
      do_reset();
      bus.imem_ready = 1'b1;
      step();
      step();
      step();
      chk_ir("t5_pre", 1'b1, 32'h0);
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'hFFFF_FFFC;
      step();
      chk32("t5_addr_tgt", bus.imem_addr, 32'hFFFF_FFFC);
      chk1("t5_req", bus.imem_req, 1'b1);
      chk_ir("t5_nopop", 1'b0, 32'h0);
      bus.redirect = 1'b0;
      step();
      chk32("t5_wrap_addr", bus.imem_addr, 32'h0);
      chk_ir("t5_e5", 1'b0, 32'h0);
      step();
      chk_ir("t5_top", 1'b1, 32'hFFFF_FFFC);
      step();
      chk_ir("t5_wrap", 1'b1, 32'h0);

      // T6: misaligned redirect, then reset mid-fetch
      do_reset();
      bus.imem_ready = 1'b1;
      step();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h0000_0102;
      step();
      chk32("t6_addr_al", bus.imem_addr, 32'h100);
`ifdef FETCH_ALIGN_CHECK_EN
      chk1("t6_mis_set", misaligned, 1'b1);
`endif
      bus.redirect = 1'b0;
      step();
      step();
      chk_ir("t6_first", 1'b1, 32'h100);
`ifdef FETCH_ALIGN_CHECK_EN
      chk1("t6_mis_stick", misaligned, 1'b1);
`endif
      bus.imem_ready = 1'b0;
      step();
      chk_ir("t6_second", 1'b1, 32'h104);
      chk1("t6_pend_req", bus.imem_req, 1'b1);
      chk32("t6_pend_addr", bus.imem_addr, 32'h108);
      #2 reset = 1'b0;
      #1;
      chk1("t6_rst_req", bus.imem_req, 1'b0);
      chk32("t6_rst_addr", bus.imem_addr, 32'h0);
      chk1("t6_rst_ld", bus.ir_load, 1'b0);
      chk32("t6_rst_ins", bus.ir_instruction, 32'h0);
      chk32("t6_rst_pc", bus.ir_pc, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
      chk1("t6_rst_mis", misaligned, 1'b0);
`endif
      step();
      reset          = 1'b1;
      bus.imem_ready = 1'b1;
      step();
      chk1("t6_restart_req", bus.imem_req, 1'b1);
      chk32("t6_restart_addr", bus.imem_addr, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end
endmodule
